// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage: fetch PC, credit-based word fetch, {pc, inst} FIFO
module if_fetch_unit #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [29:0] mem_addr_I,
    input  logic [31:0] mem_rdata_I,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        valid_o,
    input  logic        ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 2;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]   fetch_pc_q;
    logic          inflight_q;
    logic [31:0]   req_pc_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW:0]   count_q;
    logic [63:0]   fifo_q [DEPTH];

    logic          pop;
    logic          push;
    logic          issue;
    logic [CW-1:0] credit_used;
    logic [63:0]   head;

    assign mem_addr_I = fetch_pc_q[31:2];

    assign valid_o = (count_q != '0);
    assign pop     = valid_o & ready_i;
    assign push    = inflight_q & ~redirect_i;

    // Words already buffered plus the one on its way back, minus what leaves now.
    assign credit_used = {1'b0, count_q}
                       + {{(CW-1){1'b0}}, inflight_q}
                       - {{(CW-1){1'b0}}, pop};
    assign issue = ~rst_n & ~redirect_i & (credit_used < DEPTH_C);

    assign head   = fifo_q[rd_ptr_q];
    assign inst_o = valid_o ? head[31:0]  : 32'h0;
    assign pc_o   = valid_o ? head[63:32] : 32'h0;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            fetch_pc_q <= RESET_PC;
            inflight_q <= 1'b0;
            req_pc_q   <= 32'h0;
        end else if (redirect_i) begin
            fetch_pc_q <= {redirect_pc_i[31:2], 2'b00};
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                req_pc_q   <= fetch_pc_q;
                fetch_pc_q <= fetch_pc_q + 32'd4;
            end
        end
    end

    // A redirect in the same cycle drops both the push and the pop.
    always_ff @(posedge clk) begin
        if (rst_n || redirect_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n && push) begin
            fifo_q[wr_ptr_q] <= {req_pc_q, mem_rdata_I};
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed bench for if_fetch_unit with a one-cycle-latency memory
module tb_if_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        ready_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;

    logic [29:0] mem_addr_I;
    logic [31:0] mem_rdata_I;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        valid_o;

    logic [29:0] w_mem_addr;
    logic [31:0] w_mem_rdata;
    logic [31:0] w_inst;
    logic [31:0] w_pc;
    logic        w_valid;

    int n_checks = 0;
    int n_errors = 0;

    if_fetch_unit #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .mem_addr_I(mem_addr_I), .mem_rdata_I(mem_rdata_I),
        .inst_o(inst_o), .pc_o(pc_o), .valid_o(valid_o), .ready_i(ready_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i)
    );

    if_fetch_unit #(.DEPTH(2), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .mem_addr_I(w_mem_addr), .mem_rdata_I(w_mem_rdata),
        .inst_o(w_inst), .pc_o(w_pc), .valid_o(w_valid), .ready_i(ready_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns {2'b00, word address} one cycle after the address.
    always @(posedge clk) begin
        mem_rdata_I <= {2'b00, mem_addr_I};
        w_mem_rdata <= {2'b00, w_mem_addr};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n         = 1'b1;
        ready_i       = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        tick();
        tick();
        chk("rst_valid", {31'h0, valid_o}, 32'h0);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_addr", {2'b00, mem_addr_I}, 32'h0);
        chk("rst_wrap_addr", {2'b00, w_mem_addr}, 32'h3FFF_FFFE);

        // Free-running stream from reset
        rst_n = 1'b0;
        chk("c0_valid", {31'h0, valid_o}, 32'h0);
        tick();
        chk("c1_valid", {31'h0, valid_o}, 32'h0);
        tick();
        for (int k = 2; k < 10; k++) begin
            chk("stream_valid", {31'h0, valid_o}, 32'h1);
            chk("stream_pc", pc_o, 32'(4 * (k - 2)));
            chk("stream_inst", inst_o, 32'(k - 2));
            tick();
        end

        // Redirect from a steady stream
        chk("pre_redir_pc", pc_o, 32'h20);
        chk("wrap_late_valid", {31'h0, w_valid}, 32'h1);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        tick();
        redirect_i = 1'b0;
        chk("redir_addr", {2'b00, mem_addr_I}, 32'h40);
        chk("redir_v1", {31'h0, valid_o}, 32'h0);
        tick();
        chk("redir_v2", {31'h0, valid_o}, 32'h0);
        tick();
        chk("redir_pc0", pc_o, 32'h100);
        chk("redir_inst0", inst_o, 32'h40);
        tick();
        chk("redir_pc1", pc_o, 32'h104);

        // Unaligned target is word-aligned
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h103;
        tick();
        redirect_i = 1'b0;
        chk("unal_v1", {31'h0, valid_o}, 32'h0);
        tick();
        chk("unal_v2", {31'h0, valid_o}, 32'h0);
        tick();
        chk("unal_pc", pc_o, 32'h100);

        // Back-to-back redirects: last target wins
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h200;
        tick();
        redirect_pc_i = 32'h300;
        chk("b2b_v0", {31'h0, valid_o}, 32'h0);
        tick();
        redirect_i = 1'b0;
        chk("b2b_addr", {2'b00, mem_addr_I}, 32'hC0);
        chk("b2b_v1", {31'h0, valid_o}, 32'h0);
        tick();
        chk("b2b_v2", {31'h0, valid_o}, 32'h0);
        tick();
        chk("b2b_pc0", pc_o, 32'h300);
        tick();
        chk("b2b_pc1", pc_o, 32'h304);

        // Reset, then stall downstream from c0
        rst_n = 1'b1;
        tick();
        rst_n   = 1'b0;
        ready_i = 1'b0;
        tick();
        tick();
        tick();
        for (int k = 3; k < 6; k++) begin
            chk("stall_addr", {2'b00, mem_addr_I}, 32'h2);
            chk("stall_valid", {31'h0, valid_o}, 32'h1);
            chk("stall_pc", pc_o, 32'h0);
            tick();
        end
        ready_i = 1'b1;
        for (int k = 6; k < 10; k++) begin
            chk("drain_pc", pc_o, 32'(4 * (k - 6)));
            chk("drain_inst", inst_o, 32'(k - 6));
            if (k == 9) ready_i = 1'b0;
            tick();
        end
        chk("hold_pc", pc_o, 32'hC);
        tick();
        tick();
        chk("full_valid", {31'h0, valid_o}, 32'h1);
        chk("full_pc", pc_o, 32'hC);

        // Reset with a full FIFO
        rst_n = 1'b1;
        tick();
        chk("midrst_valid", {31'h0, valid_o}, 32'h0);
        chk("midrst_addr", {2'b00, mem_addr_I}, 32'h0);
        chk("midrst_pc", pc_o, 32'h0);
        chk("midrst_inst", inst_o, 32'h0);
        rst_n   = 1'b0;
        ready_i = 1'b1;
        tick();
        tick();
        chk("restart_pc0", pc_o, 32'h0);
        chk("wrap_pc0", w_pc, 32'hFFFF_FFF8);
        chk("wrap_inst0", w_inst, 32'h3FFF_FFFE);
        tick();
        chk("restart_pc1", pc_o, 32'h4);
        chk("wrap_pc1", w_pc, 32'hFFFF_FFFC);
        tick();
        chk("wrap_pc2", w_pc, 32'h0000_0000);
        chk("wrap_inst2", w_inst, 32'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
